// File: rtl/hid_report_arbiter.sv
// Shares one HID report display register among up to three usb_hid_host ports.
// Optional stale-owner detection is enabled with `define HID_ARB_STALE_EN.
module hid_report_arbiter #(
   parameter int NPORTS       = 3,
   parameter int REPORT_BITS  = 64,
   parameter int DWELL_CYCLES = 12000000,
   parameter int STALE_CYCLES = 6000000
) (
   input  logic                          usbclk,
   input  logic                          usbrst_n,
   input  logic [NPORTS-1:0]             rep_stb,
   input  logic [NPORTS*REPORT_BITS-1:0] rep_data,
   input  logic [NPORTS*2-1:0]           rep_typ,
   input  logic [NPORTS-1:0]             rep_conerr,
   input  logic                          man_en,
   input  logic [1:0]                    man_port,
   output logic [REPORT_BITS-1:0]        disp_data,
   output logic [1:0]                    disp_port,
   output logic [1:0]                    disp_typ,
   output logic                          disp_stb,
   output logic [NPORTS-1:0]             fresh,
   output logic                          disp_stale
);

   if (NPORTS < 1 || NPORTS > 3)
      $error("NPORTS out of range");
   if (DWELL_CYCLES < 2 || DWELL_CYCLES > 24'hFFFFFF)
      $error("DWELL_CYCLES out of range");
   if (STALE_CYCLES < 1 || STALE_CYCLES > 24'hFFFFFF)
      $error("STALE_CYCLES out of range");

   typedef enum logic {
      ST_ARB,
      ST_HOLD
   } state_t;

   state_t                  r_state;
   logic [REPORT_BITS-1:0]  r_buf [NPORTS];
   logic [NPORTS-1:0]       r_fresh;
   logic [1:0]              r_last;
   logic [23:0]             r_dwell;
   logic [REPORT_BITS-1:0]  r_disp_data;
   logic [1:0]              r_disp_port;
   logic [1:0]              r_disp_typ;
   logic                    r_disp_stb;

   logic [NPORTS-1:0]       w_elig;
   logic [NPORTS-1:0]       w_cand;
   logic                    w_pick_vld;
   logic [1:0]              w_pick;
   logic                    w_owner_elig;
   logic                    w_owner_fresh;
   logic                    w_leave;
   logic                    w_load;
   logic [1:0]              w_load_port;
   logic [REPORT_BITS-1:0]  w_data_sel;
   logic [1:0]              w_typ_sel;

   always_comb begin
      int idx;
      idx           = 0;
      w_elig        = '0;
      w_cand        = '0;
      w_pick_vld    = 1'b0;
      w_pick        = 2'd0;
      w_owner_elig  = 1'b0;
      w_owner_fresh = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         w_elig[i] = (rep_typ[2*i +: 2] != 2'd0) && !rep_conerr[i];
         w_cand[i] = r_fresh[i] && (!man_en || man_port == 2'(i));
         if (r_disp_port == 2'(i)) begin
            w_owner_elig  = w_elig[i];
            w_owner_fresh = r_fresh[i];
         end
      end
      // Round-robin search starting just after the last granted port
      for (int k = 1; k <= NPORTS; k++) begin
         idx = (int'(r_last) + k) % NPORTS;
         if (!w_pick_vld && w_cand[idx]) begin
            w_pick_vld = 1'b1;
            w_pick     = 2'(idx);
         end
      end
   end

   always_comb begin
      w_leave     = !w_owner_elig ||
                    (man_en && man_port != r_disp_port);
      w_load      = 1'b0;
      w_load_port = r_disp_port;
      // No load while disp_stb is high keeps pulses one cycle apart
      if (r_state == ST_ARB) begin
         if (w_pick_vld && !r_disp_stb) begin
            w_load      = 1'b1;
            w_load_port = w_pick;
         end
      end else if (!w_leave && w_owner_fresh && !r_disp_stb) begin
         w_load = 1'b1;
      end
   end

   always_comb begin
      w_data_sel = '0;
      w_typ_sel  = 2'd0;
      for (int i = 0; i < NPORTS; i++) begin
         if (w_load_port == 2'(i)) begin
            w_data_sel = r_buf[i];
            w_typ_sel  = rep_typ[2*i +: 2];
         end
      end
   end

   always_ff @(posedge usbclk or negedge usbrst_n) begin
      if (!usbrst_n) begin
         for (int i = 0; i < NPORTS; i++)
            r_buf[i] <= '0;
         r_fresh <= '0;
      end else begin
         for (int i = 0; i < NPORTS; i++) begin
            if (rep_stb[i] && w_elig[i])
               r_buf[i] <= rep_data[i*REPORT_BITS +: REPORT_BITS];
            r_fresh[i] <= (rep_stb[i] && w_elig[i]) ||
                          (r_fresh[i] && w_elig[i] &&
                           !(w_load && w_load_port == 2'(i)));
         end
      end
   end

   always_ff @(posedge usbclk or negedge usbrst_n) begin
      if (!usbrst_n) begin
         r_state     <= ST_ARB;
         r_last      <= 2'(NPORTS - 1);
         r_dwell     <= '0;
         r_disp_data <= '0;
         r_disp_port <= 2'd0;
         r_disp_typ  <= 2'd0;
         r_disp_stb  <= 1'b0;
      end else begin
         r_disp_stb <= w_load;
         if (w_load) begin
            r_disp_data <= w_data_sel;
            r_disp_port <= w_load_port;
            r_disp_typ  <= w_typ_sel;
         end
         unique case (r_state)
            ST_ARB: begin
               if (w_load) begin
                  r_last  <= w_pick;
                  r_dwell <= 24'(DWELL_CYCLES - 1);
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_leave || r_dwell == 24'd0)
                  r_state <= ST_ARB;
               else
                  r_dwell <= r_dwell - 24'd1;
            end
         endcase
      end
   end

`ifdef HID_ARB_STALE_EN
   logic [23:0] r_stale_cnt;

   always_ff @(posedge usbclk or negedge usbrst_n) begin
      if (!usbrst_n)
         r_stale_cnt <= '0;
      else if (r_disp_stb)
         r_stale_cnt <= '0;
      else if (r_stale_cnt != 24'hFFFFFF)
         r_stale_cnt <= r_stale_cnt + 24'd1;
   end

   assign disp_stale = (r_stale_cnt >= 24'(STALE_CYCLES)) &&
                       !r_disp_stb;
`else
   assign disp_stale = 1'b0;
`endif

   assign disp_data = r_disp_data;
   assign disp_port = r_disp_port;
   assign disp_typ  = r_disp_typ;
   assign disp_stb  = r_disp_stb;
   assign fresh     = r_fresh;

endmodule
